// File: rtl/bram_port_arbiter.sv
// Arbitrates the lockstep x/y/z point-cloud BRAM ports between core bursts, feeder reads and
// outlier write-back clears, returning read data tagged to the requester that issued it.
module bram_port_arbiter #(
    parameter int BUS_SIZE     = 64,
    parameter int BRAM_SHIFT   = 2,
    parameter int CORE_BEATS   = 5,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                core_req,
    input  logic [31:0]         core_base,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic                core_done,
    input  logic                feed_req,
    input  logic [31:0]         feed_addr,
    output logic                feed_gnt,
    output logic                feed_rvalid,
    input  logic                wb_req,
    input  logic [31:0]         wb_addr,
    output logic                wb_gnt,
    output logic [BUS_SIZE-1:0] rd_x,
    output logic [BUS_SIZE-1:0] rd_y,
    output logic [BUS_SIZE-1:0] rd_z,
    output logic [31:0]         addr_x,
    output logic [31:0]         addr_y,
    output logic [31:0]         addr_z,
    output logic [BUS_SIZE-1:0] write_in_x,
    output logic [BUS_SIZE-1:0] write_in_y,
    output logic [BUS_SIZE-1:0] write_in_z,
    output logic                en_x,
    output logic                en_y,
    output logic                en_z,
    output logic                rst_x,
    output logic                rst_y,
    output logic                rst_z,
    output logic [3:0]          we_x,
    output logic [3:0]          we_y,
    output logic [3:0]          we_z,
    input  logic [BUS_SIZE-1:0] read_out_x,
    input  logic [BUS_SIZE-1:0] read_out_y,
    input  logic [BUS_SIZE-1:0] read_out_z,
    output logic                busy
);

    localparam int BEAT_W   = (CORE_BEATS > 1) ? $clog2(CORE_BEATS) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(CORE_BEATS - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic TAG_CORE = 1'b1;
    localparam logic TAG_FEED = 1'b0;

    typedef enum logic {IDLE, CORE_BURST} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d, base_q, base_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  en_q, en_d;
    logic [3:0]            we_q, we_d;
    logic                  core_gnt_q, core_gnt_d, feed_gnt_q, feed_gnt_d, wb_gnt_q, wb_gnt_d;
    logic                  tag_q, tag_d, last_q, last_d;
    logic [RD_LAT-1:0]     pv_q, pv_d, pt_q, pt_d, pl_q, pl_d;
    logic                  feed_ok, wb_ok, starved, win_core, win_feed, win_wb, rd_issue;

    // A single-beat requester granted last cycle is ignored once so a held request is not granted twice.
    assign feed_ok  = feed_req && !feed_gnt_q;
    assign wb_ok    = wb_req && !wb_gnt_q;
    assign starved  = (starve_q >= STARVE_MAX);
    assign win_core = (state_q == IDLE) && core_req;
    assign win_feed = (state_q == IDLE) && !core_req && feed_ok && (starved || !wb_ok);
    assign win_wb   = (state_q == IDLE) && !core_req && wb_ok && !(feed_ok && starved);
    assign rd_issue = en_q && (we_q == 4'h0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (win_core && (CORE_BEATS > 1)) state_d = CORE_BURST;
            CORE_BURST: if (beat_q == LAST_BEAT) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        base_d     = base_q;
        beat_d     = beat_q;
        en_d       = 1'b0;
        we_d       = 4'h0;
        core_gnt_d = 1'b0;
        feed_gnt_d = 1'b0;
        wb_gnt_d   = 1'b0;
        tag_d      = tag_q;
        last_d     = 1'b0;
        starve_d   = starve_q;
        if (state_q == CORE_BURST) begin
            en_d   = 1'b1;
            addr_d = base_q + (32'(beat_q) << BRAM_SHIFT);
            beat_d = beat_q + BEAT_W'(1);
            tag_d  = TAG_CORE;
            last_d = (beat_q == LAST_BEAT);
        end else if (win_core) begin
            core_gnt_d = 1'b1;
            en_d       = 1'b1;
            addr_d     = core_base;
            base_d     = core_base;
            beat_d     = BEAT_W'(1);
            tag_d      = TAG_CORE;
            last_d     = (CORE_BEATS == 1);
        end else if (win_feed) begin
            feed_gnt_d = 1'b1;
            en_d       = 1'b1;
            addr_d     = feed_addr;
            tag_d      = TAG_FEED;
        end else if (win_wb) begin
            wb_gnt_d = 1'b1;
            en_d     = 1'b1;
            we_d     = 4'hf;
            addr_d   = wb_addr;
        end
        if (win_feed)                                 starve_d = '0;
        else if (feed_ok && (starve_q < STARVE_MAX))  starve_d = starve_q + STARVE_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            base_q     <= '0;
            beat_q     <= '0;
            starve_q   <= '0;
            en_q       <= 1'b0;
            we_q       <= 4'h0;
            core_gnt_q <= 1'b0;
            feed_gnt_q <= 1'b0;
            wb_gnt_q   <= 1'b0;
            tag_q      <= 1'b0;
            last_q     <= 1'b0;
            pv_q       <= '0;
            pt_q       <= '0;
            pl_q       <= '0;
        end else begin
            addr_q     <= addr_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            en_q       <= en_d;
            we_q       <= we_d;
            core_gnt_q <= core_gnt_d;
            feed_gnt_q <= feed_gnt_d;
            wb_gnt_q   <= wb_gnt_d;
            tag_q      <= tag_d;
            last_q     <= last_d;
            pv_q       <= pv_d;
            pt_q       <= pt_d;
            pl_q       <= pl_d;
        end
    end

    // Read-return shift: the top stage lines up with the BRAM data RD_LAT cycles after issue.
    generate
        if (RD_LAT == 1) begin : g_pipe_one
            assign pv_d = rd_issue;
            assign pt_d = tag_q;
            assign pl_d = last_q;
        end else begin : g_pipe_deep
            assign pv_d = {pv_q[RD_LAT-2:0], rd_issue};
            assign pt_d = {pt_q[RD_LAT-2:0], tag_q};
            assign pl_d = {pl_q[RD_LAT-2:0], last_q};
        end
    endgenerate

    assign core_gnt    = core_gnt_q;
    assign feed_gnt    = feed_gnt_q;
    assign wb_gnt      = wb_gnt_q;
    assign core_rvalid = pv_q[RD_LAT-1] && (pt_q[RD_LAT-1] == TAG_CORE);
    assign feed_rvalid = pv_q[RD_LAT-1] && (pt_q[RD_LAT-1] == TAG_FEED);
    assign core_done   = core_rvalid && pl_q[RD_LAT-1];
    assign busy        = (state_q != IDLE) || rd_issue || (|pv_q);

    assign rd_x       = read_out_x;
    assign rd_y       = read_out_y;
    assign rd_z       = read_out_z;
    assign addr_x     = addr_q;
    assign addr_y     = addr_q;
    assign addr_z     = addr_q;
    assign en_x       = en_q;
    assign en_y       = en_q;
    assign en_z       = en_q;
    assign we_x       = we_q;
    assign we_y       = we_q;
    assign we_z       = we_q;
    assign write_in_x = '0;
    assign write_in_y = '0;
    assign write_in_z = '0;
    assign rst_x      = 1'b0;
    assign rst_y      = 1'b0;
    assign rst_z      = 1'b0;

endmodule
